// File: rtl/cpu_test_monitor_pkg.sv
// Shared constants for the CPU test monitor: word size, FSM encodings,
// termination reason codes and per-test status codes.
package cpu_test_monitor_pkg;

    localparam int WORD_SIZE = 16;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // done_reason codes
    localparam logic [1:0] RSN_ALL     = 2'b00;
    localparam logic [1:0] RSN_HALT    = 2'b01;
    localparam logic [1:0] RSN_TIMEOUT = 2'b10;
    localparam logic [1:0] RSN_FAIL    = 2'b11;

    // per-test status codes
    localparam logic [1:0] STAT_NONE  = 2'b00;
    localparam logic [1:0] STAT_PASS  = 2'b01;
    localparam logic [1:0] STAT_WRONG = 2'b10;

endpackage

// File: rtl/cpu_test_monitor_checkpoint_table.sv
// Checkpoint storage: NUM_TEST x (num_inst, ans) register file with one
// write port and one async read port, plus a resettable 2-bit status array
// with its own write port, bulk clear and async readback.
module checkpoint_table
    import cpu_test_monitor_pkg::*;
#(
    parameter int W        = WORD_SIZE,
    parameter int NUM_TEST = 56,
    parameter int IDX_W    = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    // entry write / read
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [W-1:0]     wr_num_inst,
    input  logic [W-1:0]     wr_ans,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_num_inst,
    output logic [W-1:0]     rd_ans,
    // status write / clear / read
    input  logic             st_clr,
    input  logic             st_we,
    input  logic [IDX_W-1:0] st_wr_idx,
    input  logic [1:0]       st_wr_val,
    input  logic [IDX_W-1:0] st_rd_idx,
    output logic [1:0]       st_rd_val
);

    localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(NUM_TEST);

    logic [W-1:0] num_mem [NUM_TEST];
    logic [W-1:0] ans_mem [NUM_TEST];
    logic [1:0]   st_mem  [NUM_TEST];

    logic wr_ok, rd_ok, st_wr_ok, st_rd_ok;

    assign wr_ok    = ({1'b0, wr_idx}    < DEPTH);
    assign rd_ok    = ({1'b0, rd_idx}    < DEPTH);
    assign st_wr_ok = ({1'b0, st_wr_idx} < DEPTH);
    assign st_rd_ok = ({1'b0, st_rd_idx} < DEPTH);

    // Table entries survive reset so a loaded table can be re-run.
    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            num_mem[wr_idx] <= wr_num_inst;
            ans_mem[wr_idx] <= wr_ans;
        end
    end

    // Status array: reset and bulk-cleared at run start, one write per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TEST; i++) st_mem[i] <= STAT_NONE;
        end else if (st_clr) begin
            for (int i = 0; i < NUM_TEST; i++) st_mem[i] <= STAT_NONE;
        end else if (st_we && st_wr_ok) begin
            st_mem[st_wr_idx] <= st_wr_val;
        end
    end

    assign rd_num_inst = rd_ok    ? num_mem[rd_idx]   : '0;
    assign rd_ans      = rd_ok    ? ans_mem[rd_idx]   : '0;
    assign st_rd_val   = st_rd_ok ? st_mem[st_rd_idx] : STAT_NONE;

endmodule

// File: rtl/cpu_test_monitor.sv
// CPU test monitor: walks a loaded checkpoint table against the CPU's
// retired-instruction count and output port, scoring each checkpoint and
// ending on failure, halt, cycle budget or table exhaustion.
module cpu_test_monitor
    import cpu_test_monitor_pkg::*;
#(
    parameter int WORD_SIZE    = cpu_test_monitor_pkg::WORD_SIZE,
    parameter int NUM_TEST     = 56,
    parameter int IDX_W        = 6,
    parameter int CYC_W        = 16,
    parameter int MAX_CYCLES   = 10000,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tbl_we,
    input  logic [IDX_W-1:0]     tbl_idx,
    input  logic [WORD_SIZE-1:0] tbl_num_inst,
    input  logic [WORD_SIZE-1:0] tbl_ans,
    input  logic [IDX_W:0]       tbl_count,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] num_inst,
    input  logic [WORD_SIZE-1:0] output_port,
    input  logic                 is_halted,
    input  logic [IDX_W-1:0]     stat_idx,
    output logic [1:0]           stat_out,
    output logic                 running,
    output logic                 done,
    output logic [1:0]           done_reason,
    output logic [IDX_W:0]       pass_count,
    output logic [IDX_W:0]       fail_count,
    output logic [IDX_W-1:0]     first_fail,
    output logic [WORD_SIZE-1:0] fail_value,
    output logic [CYC_W-1:0]     num_clock
);

    logic [1:0]           state;
    logic [IDX_W:0]       ptr;
    logic [IDX_W:0]       cnt_q;

    logic [WORD_SIZE-1:0] e_num, e_ans;
    logic                 in_run, have_entry, hit, skip, mismatch, timeout;
    logic [IDX_W:0]       ptr_nxt;
    logic [CYC_W-1:0]     clk_nxt;
    logic                 finish;
    logic [1:0]           fin_reason;

    checkpoint_table #(
        .W        (WORD_SIZE),
        .NUM_TEST (NUM_TEST),
        .IDX_W    (IDX_W)
    ) u_table (
        .clk         (clk),
        .reset_n     (reset_n),
        .we          (tbl_we && (state == ST_IDLE)),
        .wr_idx      (tbl_idx),
        .wr_num_inst (tbl_num_inst),
        .wr_ans      (tbl_ans),
        .rd_idx      (ptr[IDX_W-1:0]),
        .rd_num_inst (e_num),
        .rd_ans      (e_ans),
        .st_clr      (start && (state == ST_IDLE)),
        .st_we       (hit),
        .st_wr_idx   (ptr[IDX_W-1:0]),
        .st_wr_val   (mismatch ? STAT_WRONG : STAT_PASS),
        .st_rd_idx   (stat_idx),
        .st_rd_val   (stat_out)
    );

    // Only entry[ptr] is examined; a passed-over checkpoint is skipped unscored.
    assign in_run     = (state == ST_RUN);
    assign have_entry = (ptr < cnt_q);
    assign hit        = in_run && have_entry && (num_inst == e_num);
    assign skip       = in_run && have_entry && (num_inst >  e_num);
    assign mismatch   = hit && (output_port != e_ans);
    assign ptr_nxt    = ptr + {{IDX_W{1'b0}}, (hit | skip)};
    assign clk_nxt    = (num_clock == '1) ? num_clock : num_clock + CYC_W'(1);
    assign timeout    = (MAX_CYCLES != 0) && (clk_nxt == CYC_W'(MAX_CYCLES));

    // Termination decision for this RUN cycle, after the same-cycle check.
    always_comb begin
        finish     = 1'b1;
        fin_reason = RSN_ALL;
        if (mismatch && (STOP_ON_FAIL != 0)) fin_reason = RSN_FAIL;
        else if (is_halted)                  fin_reason = RSN_HALT;
        else if (timeout)                    fin_reason = RSN_TIMEOUT;
        else if (ptr_nxt >= cnt_q)           fin_reason = RSN_ALL;
        else                                 finish     = 1'b0;
    end

    // FSM, pointer, counters and first-failure capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cnt_q       <= '0;
            pass_count  <= '0;
            fail_count  <= '0;
            first_fail  <= '0;
            fail_value  <= '0;
            num_clock   <= '0;
            done_reason <= RSN_ALL;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_RUN;
                        cnt_q       <= tbl_count;
                        ptr         <= '0;
                        pass_count  <= '0;
                        fail_count  <= '0;
                        first_fail  <= '0;
                        fail_value  <= '0;
                        num_clock   <= '0;
                        done_reason <= RSN_ALL;
                    end
                end
                ST_RUN: begin
                    num_clock <= clk_nxt;
                    ptr       <= ptr_nxt;
                    if (hit) begin
                        if (mismatch) begin
                            fail_count <= fail_count + (IDX_W+1)'(1);
                            if (fail_count == '0) begin
                                first_fail <= ptr[IDX_W-1:0];
                                fail_value <= output_port;
                            end
                        end else begin
                            pass_count <= pass_count + (IDX_W+1)'(1);
                        end
                    end
                    if (finish) begin
                        state       <= ST_DONE;
                        done_reason <= fin_reason;
                    end
                end
                ST_DONE: begin
                    if (start) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Scoreboard bench: three monitors (stop-on-fail, keep-running, 20-cycle
// budget) share one stimulus stream; expected end-of-run results come from
// a per-cycle reference walk over the checkpoint list.
module tb_cpu_test_monitor;

    typedef struct packed {
        logic [1:0]       reason;
        logic [6:0]       pass;
        logic [6:0]       fail;
        logic [5:0]       ff;
        logic [15:0]      fv;
        logic [15:0]      nclk;
        logic [31:0]      lat;
        logic [55:0][1:0] stat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tbl_we;
    logic [5:0]  tbl_idx;
    logic [15:0] tbl_num_inst, tbl_ans;
    logic [6:0]  tbl_count;
    logic        start;
    logic [15:0] num_inst, output_port;
    logic        is_halted;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_start = 0;

    int tab_ni [56];
    int tab_ans[56];
    int s_ni [$];
    int s_out[$];
    bit s_halt[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [1:0]  stat_out, done_reason;
        logic        running, done;
        logic [6:0]  pass_count, fail_count;
        logic [5:0]  first_fail, stat_idx;
        logic [15:0] fail_value, num_clock;
        exp_t        q[$];
        bit          busy;

        cpu_test_monitor #(
            .WORD_SIZE    (16),
            .NUM_TEST     (56),
            .IDX_W        (6),
            .CYC_W        (16),
            .MAX_CYCLES   (g == 2 ? 20 : (g == 0 ? 10000 : 0)),
            .STOP_ON_FAIL (g == 1 ? 0 : 1)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .tbl_we       (tbl_we),
            .tbl_idx      (tbl_idx),
            .tbl_num_inst (tbl_num_inst),
            .tbl_ans      (tbl_ans),
            .tbl_count    (tbl_count),
            .start        (start),
            .num_inst     (num_inst),
            .output_port  (output_port),
            .is_halted    (is_halted),
            .stat_idx     (stat_idx),
            .stat_out     (stat_out),
            .running      (running),
            .done         (done),
            .done_reason  (done_reason),
            .pass_count   (pass_count),
            .fail_count   (fail_count),
            .first_fail   (first_fail),
            .fail_value   (fail_value),
            .num_clock    (num_clock)
        );

        // Monitor: on each rising done, pop the expected result and compare.
        initial begin : mon
            bit               seen;
            exp_t             e;
            logic [55:0][1:0] sv;
            seen = 1'b0;
            busy = 1'b0;
            stat_idx = '0;
            forever begin
                @(negedge clk);
                if (done && !seen) begin
                    seen = 1'b1;
                    if (q.size() == 0) begin
                        chk($sformatf("dut%0d unexpected_done qsize", g), q.size(), 1);
                    end else begin
                        busy = 1'b1;
                        e = q.pop_front();
                        chk($sformatf("dut%0d reason", g), int'(done_reason), int'(e.reason));
                        chk($sformatf("dut%0d latency", g), cyc - run_start, int'(e.lat));
                        chk($sformatf("dut%0d num_clock", g), int'(num_clock), int'(e.nclk));
                        chk($sformatf("dut%0d pass_count", g), int'(pass_count), int'(e.pass));
                        chk($sformatf("dut%0d fail_count", g), int'(fail_count), int'(e.fail));
                        if (e.fail != 0) begin
                            chk($sformatf("dut%0d first_fail", g), int'(first_fail), int'(e.ff));
                            chk($sformatf("dut%0d fail_value", g), int'(fail_value), int'(e.fv));
                        end
                        for (int i = 0; i < 56; i++) begin
                            stat_idx = 6'(i);
                            #1;
                            sv[i] = stat_out;
                        end
                        stat_idx = '0;
                        checks++;
                        if (sv !== e.stat) begin
                            errors++;
                            $display("FAIL dut%0d status actual=%h expected=%h", g, sv, e.stat);
                        end
                        busy = 1'b0;
                    end
                end else if (!done) begin
                    seen = 1'b0;
                end
            end
        end
    end

    // Reference: walk the sequence cycle by cycle over the checkpoint list.
    function automatic exp_t model(input int cnt, input int stop, input int maxc);
        exp_t e;
        int   p;
        bit   fin, mis;
        e = '0;
        p = 0;
        fin = 0;
        for (int c = 0; c < s_ni.size() && !fin; c++) begin
            mis = 0;
            e.nclk = 16'(c + 1);
            if (p < cnt) begin
                if (s_ni[c] == tab_ni[p]) begin
                    if (s_out[c] == tab_ans[p]) begin
                        e.pass = e.pass + 7'd1;
                        e.stat[p] = 2'd1;
                    end else begin
                        mis = 1;
                        if (e.fail == 0) begin
                            e.ff = 6'(p);
                            e.fv = 16'(s_out[c]);
                        end
                        e.fail = e.fail + 7'd1;
                        e.stat[p] = 2'd2;
                    end
                    p++;
                end else if (s_ni[c] > tab_ni[p]) begin
                    p++;
                end
            end
            fin = 1;
            if (mis && stop != 0)             e.reason = 2'd3;
            else if (s_halt[c])               e.reason = 2'd1;
            else if (maxc != 0 && c+1 == maxc) e.reason = 2'd2;
            else if (p >= cnt)                e.reason = 2'd0;
            else                              fin = 0;
            if (fin) e.lat = 32'(c + 1);
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_seq();
        s_ni.delete();
        s_out.delete();
        s_halt.delete();
    endtask

    task automatic add(input int ni, input int o, input bit h);
        s_ni.push_back(ni);
        s_out.push_back(o);
        s_halt.push_back(h);
    endtask

    task automatic set3();
        tab_ni[0] = 3; tab_ans[0] = 0;
        tab_ni[1] = 5; tab_ans[1] = 0;
        tab_ni[2] = 7; tab_ans[2] = 1;
    endtask

    task automatic load(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            tbl_we = 1'b1;
            tbl_idx = 6'(i);
            tbl_num_inst = 16'(tab_ni[i]);
            tbl_ans = 16'(tab_ans[i]);
            step();
        end
        tbl_we = 1'b0;
    endtask

    // One full run: optional load, start, drive sequence, drain, re-arm.
    task automatic run_test(input int cnt, input bit do_load);
        int t;
        if (do_load) load(cnt);
        g_dut[0].q.push_back(model(cnt, 1, 10000));
        g_dut[1].q.push_back(model(cnt, 0, 0));
        g_dut[2].q.push_back(model(cnt, 1, 20));
        tbl_count = 7'(cnt);
        start = 1'b1;
        step();
        start = 1'b0;
        run_start = cyc;
        for (int c = 0; c < s_ni.size(); c++) begin
            num_inst = 16'(s_ni[c]);
            output_port = 16'(s_out[c]);
            is_halted = s_halt[c];
            // table writes outside IDLE must be ignored
            tbl_we = 1'($urandom_range(0, 1));
            tbl_idx = 6'($urandom_range(0, 55));
            tbl_num_inst = 16'($urandom);
            tbl_ans = 16'($urandom);
            step();
        end
        is_halted = 1'b0;
        tbl_we = 1'b0;
        t = 0;
        while ((g_dut[0].q.size() != 0 || g_dut[1].q.size() != 0 || g_dut[2].q.size() != 0 ||
                g_dut[0].busy || g_dut[1].busy || g_dut[2].busy) && t < 300) begin
            step();
            t++;
        end
        chk("drain_within_budget", int'(t < 300), 1);
        g_dut[0].q.delete();
        g_dut[1].q.delete();
        g_dut[2].q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    initial begin
        int cnt, v, cur, len, o;
        reset_n = 1'b0;
        tbl_we = 1'b0; tbl_idx = '0; tbl_num_inst = '0; tbl_ans = '0;
        tbl_count = '0; start = 1'b0;
        num_inst = '0; output_port = '0; is_halted = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst done", int'(g_dut[0].done), 0);
        chk("rst running", int'(g_dut[0].running), 0);
        chk("rst pass_count", int'(g_dut[0].pass_count), 0);
        chk("rst fail_count", int'(g_dut[2].fail_count), 0);
        chk("rst num_clock", int'(g_dut[1].num_clock), 0);
        chk("rst done_reason", int'(g_dut[0].done_reason), 0);
        chk("rst stat0", int'(g_dut[0].stat_out), 0);
        reset_n = 1'b1;
        step();

        // all checkpoints matched
        set3(); clr_seq();
        for (int n = 0; n <= 7; n++) add(n, (n == 7) ? 1 : 0, 0);
        add(7, 0, 1);
        run_test(3, 1);

        // wrong value at second checkpoint
        clr_seq();
        for (int n = 0; n <= 7; n++) add(n, (n == 5) ? 2 : ((n == 7) ? 1 : 0), 0);
        add(7, 0, 1);
        run_test(3, 1);

        // checkpoint 5 skipped
        clr_seq();
        for (int n = 0; n <= 7; n++) if (n != 5) add(n, (n == 7) ? 1 : 0, 0);
        add(7, 0, 1);
        run_test(3, 1);

        // frozen count: budget expires
        clr_seq();
        for (int n = 0; n < 25; n++) add(0, 0, 0);
        add(0, 0, 1);
        run_test(3, 1);

        // halt on a matching checkpoint
        clr_seq();
        for (int n = 0; n <= 5; n++) add(n, 0, (n == 5));
        run_test(3, 1);

        // async reset mid-run
        tbl_count = 7'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n <= 3; n++) begin
            num_inst = 16'(n);
            output_port = 16'd0;
            step();
        end
        chk("pre_reset running", int'(g_dut[0].running), 1);
        chk("pre_reset pass_count", int'(g_dut[0].pass_count), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_reset running", int'(g_dut[0].running), 0);
        chk("mid_reset pass_count", int'(g_dut[0].pass_count), 0);
        chk("mid_reset num_clock", int'(g_dut[0].num_clock), 0);
        chk("mid_reset stat0", int'(g_dut[0].stat_out), 0);
        step();
        reset_n = 1'b1;
        step();

        // table retained across reset: rerun without reloading
        clr_seq();
        for (int n = 0; n <= 7; n++) add(n, (n == 7) ? 1 : 0, 0);
        add(7, 0, 1);
        run_test(3, 0);

        // randomized tables and instruction streams
        for (int r = 0; r < 20; r++) begin
            cnt = $urandom_range(1, 8);
            v = $urandom_range(0, 3);
            for (int i = 0; i < cnt; i++) begin
                v += $urandom_range(1, 3);
                tab_ni[i] = v;
                tab_ans[i] = $urandom_range(0, 3);
            end
            clr_seq();
            cur = 0;
            len = $urandom_range(5, 40);
            for (int c = 0; c < len; c++) begin
                o = $urandom_range(0, 3);
                for (int j = 0; j < cnt; j++)
                    if (tab_ni[j] == cur && $urandom_range(0, 3) != 0) o = tab_ans[j];
                add(cur, o, ($urandom_range(0, 29) == 0));
                cur += $urandom_range(0, 2);
            end
            add(cur, 0, 1);
            run_test(cnt, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
